fetch_stage: RTL and testbench

Instruction-fetch stage of the 3-stage RV32I core, directly upstream of the decode control unit. It owns the PC and drives the synchronous BIOS/IMEM read ports. It presents the fetched instruction and its PC to decode, and honours load-use Hold and branch/jump redirects from execute.
Wrong-path and boot-time slots are replaced with a canonical NOP, so decode never sees garbage.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage_next_pc.sv | 29 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and encodings for the RV32I fetch stage.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
   localparam logic [3:0]  BIOS_REGION  = 4'b0100;
   localparam logic [3:0]  IMEM_REGION  = 4'b0001;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_BIOS = 2'd1,
      SRC_IMEM = 2'd2
   } src_e;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_BOOT  = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   function automatic src_e region_src(input logic [3:0] nib);
      if (nib == BIOS_REGION)      return SRC_BIOS;
      else if (nib == IMEM_REGION) return SRC_IMEM;
      else                         return SRC_NONE;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: execute/decode control in, memory read ports, decode outputs.
// master = fetch stage, slave = surrounding core / memories.
interface fetch_stage_if #(
   parameter int BIOS_AW = 12,
   parameter int IMEM_AW = 14
);
   logic                hold;
   logic                redirect_valid;
   logic [31:0]         redirect_pc;
   logic [31:0]         bios_dout;
   logic [31:0]         imem_dout;
   logic [BIOS_AW-1:0]  bios_addr;
   logic                bios_en;
   logic [IMEM_AW-1:0]  imem_addr;
   logic                imem_en;
   logic [31:0]         inst_fetch;
   logic [31:0]         pc_fetch;
   logic                fetch_valid;

   modport master (
      input  hold, redirect_valid, redirect_pc, bios_dout, imem_dout,
      output bios_addr, bios_en, imem_addr, imem_en,
             inst_fetch, pc_fetch, fetch_valid
   );

   modport slave (
      output hold, redirect_valid, redirect_pc, bios_dout, imem_dout,
      input  bios_addr, bios_en, imem_addr, imem_en,
             inst_fetch, pc_fetch, fetch_valid
   );
endinterface

// File: rtl/fetch_stage_next_pc.sv
// Combinational next-PC selection and region decode for the fetch stage.
module fetch_stage_next_pc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc_q,
   input  logic        run,
   input  logic        hold,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] next_pc,
   output src_e        src,
   output logic        bios_en,
   output logic        imem_en
);

   // Redirect outranks hold: a stalled instruction behind a taken branch is wrong-path.
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (redirect_valid)
         next_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (hold || !run)
         next_pc = pc_q;
   end

   assign src     = region_src(next_pc[31:28]);
   assign bios_en = (src == SRC_BIOS);
   assign imem_en = (src == SRC_IMEM);

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives BIOS/IMEM sync reads, injects NOPs.
// Define FETCH_PERF_CNT_EN to add fetch_cnt/bubble_cnt performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          BIOS_AW  = 12,
   parameter int          IMEM_AW  = 14,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master fif
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   fetch_cnt,
   output logic [31:0]   bubble_cnt
`endif
);

   state_e      state_q, state_d;
   logic [31:0] pc_q;
   src_e        src_q;
   logic        kill_q;

   logic [31:0] next_pc;
   src_e        src_d;
   logic        bios_en, imem_en;
   logic [31:0] inst_fetch;
   logic        fetch_valid;

   fetch_stage_next_pc u_next_pc (
      .pc_q           (pc_q),
      .run            (state_q == ST_RUN),
      .hold           (fif.hold),
      .redirect_valid (fif.redirect_valid),
      .redirect_pc    (fif.redirect_pc),
      .next_pc        (next_pc),
      .src            (src_d),
      .bios_en        (bios_en),
      .imem_en        (imem_en)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_RESET;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_BOOT;
         ST_BOOT:  state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_RESET;
      endcase
   end

   // kill_q covers the BOOT slot, whose read was issued while still in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_PC;
         src_q  <= SRC_BIOS;
         kill_q <= 1'b1;
      end else begin
         pc_q   <= next_pc;
         src_q  <= src_d;
         kill_q <= (state_q == ST_RESET);
      end
   end

   always_comb begin
      inst_fetch  = NOP_INST;
      fetch_valid = 1'b0;
      if (!kill_q && !fif.redirect_valid && src_q != SRC_NONE) begin
         inst_fetch  = (src_q == SRC_BIOS) ? fif.bios_dout : fif.imem_dout;
         fetch_valid = 1'b1;
      end
   end

   assign fif.bios_addr   = next_pc[BIOS_AW+1:2];
   assign fif.imem_addr   = next_pc[IMEM_AW+1:2];
   assign fif.bios_en     = bios_en;
   assign fif.imem_en     = imem_en;
   assign fif.inst_fetch  = inst_fetch;
   assign fif.pc_fetch    = pc_q;
   assign fif.fetch_valid = fetch_valid;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (fetch_valid && !fif.hold) begin
         fetch_cnt  <= fetch_cnt + 32'd1;
      end else begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with synchronous BIOS/IMEM models.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   logic [31:0] bios_mem [4096];
   logic [31:0] imem_mem [16384];

   fetch_stage_if #(.BIOS_AW(12), .IMEM_AW(14)) fif ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, bubble_cnt;
`endif

   fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fif.bios_en) fif.bios_dout <= bios_mem[fif.bios_addr];
      if (fif.imem_en) fif.imem_dout <= imem_mem[fif.imem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic h, input logic rv, input logic [31:0] rpc);
      @(negedge clk);
      fif.hold           = h;
      fif.redirect_valid = rv;
      fif.redirect_pc    = rpc;
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      for (int i = 0; i < 4096; i++)  bios_mem[i] = 32'hB000_0000 | i;
      for (int i = 0; i < 16384; i++) imem_mem[i] = 32'hC000_0000 | i;
      bios_mem[0] = 32'h0050_0093;
      fif.bios_dout = '0;
      fif.imem_dout = '0;
      rst = 1'b0;
      fif.hold = 1'b0;
      fif.redirect_valid = 1'b0;
      fif.redirect_pc = '0;

      // reset held 3 cycles
      for (int c = 0; c < 3; c++) begin
         step(0, 0, 0);
         chk("rst_pc", fif.pc_fetch, 32'h4000_0000);
         chk("rst_inst", fif.inst_fetch, NOP);
         chk("rst_valid", {31'd0, fif.fetch_valid}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_pc", fif.pc_fetch, 32'h4000_0000);
      chk("rel_inst", fif.inst_fetch, NOP);

      // BOOT cycle
      step(0, 0, 0);
      chk("boot_inst", fif.inst_fetch, NOP);
      chk("boot_valid", {31'd0, fif.fetch_valid}, 32'd0);
      chk("boot_pc", fif.pc_fetch, 32'h4000_0000);
      chk("boot_baddr", {20'd0, fif.bios_addr}, 32'd0);

      // sequential run
      step(0, 0, 0);
      chk("run0_inst", fif.inst_fetch, 32'h0050_0093);
      chk("run0_valid", {31'd0, fif.fetch_valid}, 32'd1);
      chk("run0_pc", fif.pc_fetch, 32'h4000_0000);
      chk("run0_baddr", {20'd0, fif.bios_addr}, 32'd1);
      step(0, 0, 0);
      chk("run1_pc", fif.pc_fetch, 32'h4000_0004);
      chk("run1_inst", fif.inst_fetch, 32'hB000_0001);
      chk("run1_baddr", {20'd0, fif.bios_addr}, 32'd2);

      // hold two cycles at 4000_0008
      step(1, 0, 0);
      chk("hold0_pc", fif.pc_fetch, 32'h4000_0008);
      chk("hold0_baddr", {20'd0, fif.bios_addr}, 32'd2);
      chk("hold0_inst", fif.inst_fetch, 32'hB000_0002);
      step(1, 0, 0);
      chk("hold1_pc", fif.pc_fetch, 32'h4000_0008);
      chk("hold1_baddr", {20'd0, fif.bios_addr}, 32'd2);
      chk("hold1_inst", fif.inst_fetch, 32'hB000_0002);
      step(0, 0, 0);
      chk("unhold_pc", fif.pc_fetch, 32'h4000_0008);
      chk("unhold_inst", fif.inst_fetch, 32'hB000_0002);
      chk("unhold_baddr", {20'd0, fif.bios_addr}, 32'd3);
      step(0, 0, 0);
      chk("resume_pc", fif.pc_fetch, 32'h4000_000C);
      chk("resume_inst", fif.inst_fetch, 32'hB000_0003);
      chk("resume_baddr", {20'd0, fif.bios_addr}, 32'd4);

      // redirect into IMEM, unaligned target
      step(0, 1, 32'h1000_0013);
      chk("rimem_inst", fif.inst_fetch, NOP);
      chk("rimem_valid", {31'd0, fif.fetch_valid}, 32'd0);
      chk("rimem_iaddr", {18'd0, fif.imem_addr}, 32'd4);
      chk("rimem_ien", {31'd0, fif.imem_en}, 32'd1);
      chk("rimem_ben", {31'd0, fif.bios_en}, 32'd0);
      step(0, 0, 0);
      chk("imem_pc", fif.pc_fetch, 32'h1000_0010);
      chk("imem_inst", fif.inst_fetch, 32'hC000_0004);
      chk("imem_valid", {31'd0, fif.fetch_valid}, 32'd1);
      chk("imem_iaddr", {18'd0, fif.imem_addr}, 32'd5);

      // redirect with hold: hold ignored
      step(1, 1, 32'h4000_0100);
      chk("rh_inst", fif.inst_fetch, NOP);
      chk("rh_baddr", {20'd0, fif.bios_addr}, 32'h40);
      step(0, 0, 0);
      chk("rh_pc", fif.pc_fetch, 32'h4000_0100);
      chk("rh_tgt", fif.inst_fetch, 32'hB000_0040);
      chk("rh_valid", {31'd0, fif.fetch_valid}, 32'd1);

      // unmapped region
      step(0, 1, 32'h2000_0000);
      chk("um_en", {30'd0, fif.bios_en, fif.imem_en}, 32'd0);
      step(0, 0, 0);
      chk("um_pc", fif.pc_fetch, 32'h2000_0000);
      chk("um_inst", fif.inst_fetch, NOP);
      chk("um_valid", {31'd0, fif.fetch_valid}, 32'd0);

      // PC wrap
      step(0, 1, 32'hFFFF_FFFC);
      chk("wr_iaddr_pre", {18'd0, fif.imem_addr}, 32'h3FFF);
      step(0, 0, 0);
      chk("wr_pc", fif.pc_fetch, 32'hFFFF_FFFC);
      chk("wr_iaddr", {18'd0, fif.imem_addr}, 32'd0);
      chk("wr_valid", {31'd0, fif.fetch_valid}, 32'd0);
      step(0, 0, 0);
      chk("wr_pc0", fif.pc_fetch, 32'd0);
      chk("wr_baddr1", {20'd0, fif.bios_addr}, 32'd1);

      // reset mid-run, then redirect during BOOT
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_pc", fif.pc_fetch, 32'h4000_0000);
      chk("mrst_inst", fif.inst_fetch, NOP);
      @(negedge clk);
      rst = 1'b1;
      step(0, 1, 32'h1000_0020);
      chk("brd_inst", fif.inst_fetch, NOP);
      chk("brd_iaddr", {18'd0, fif.imem_addr}, 32'd8);
      chk("brd_ien", {31'd0, fif.imem_en}, 32'd1);
      step(0, 0, 0);
      chk("brd_pc", fif.pc_fetch, 32'h1000_0020);
      chk("brd_tgt", fif.inst_fetch, 32'hC000_0008);
      chk("brd_valid", {31'd0, fif.fetch_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
